dhcp_lease_timer: RTL and testbench

Controls when the DHCP engine transmits: issues DISCOVER requests at link-up, retries them, tracks the granted lease, and triggers renewal REQUESTs at T1 (half the lease). Drives the DHCP block's `tx_enable` and `dhcp_seconds_timer` inputs and consumes its `lease`, `dhcp_success` and `dhcp_failed` outputs. All inputs are already in the `tx_clock` domain.

---
 rtl/dhcp_lease_timer_if.sv | 24 ++
 rtl/dhcp_lease_timer.sv | 253 +++++++++++++++++++++++++
 tb/tb_dhcp_lease_timer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dhcp_lease_timer_if.sv
// Signal bundle between dhcp_lease_timer (master) and the DHCP tx/rx engine (slave).
interface dhcp_lease_timer_if;
    logic        dhcp_success;
    logic        dhcp_failed;
    logic [31:0] lease;
    logic        dhcp_request;
    logic [3:0]  dhcp_seconds_timer;

    modport master (
        input  dhcp_success,
        input  dhcp_failed,
        input  lease,
        output dhcp_request,
        output dhcp_seconds_timer
    );

    modport slave (
        output dhcp_success,
        output dhcp_failed,
        output lease,
        input  dhcp_request,
        input  dhcp_seconds_timer
    );
endinterface

// File: rtl/dhcp_lease_timer.sv
// DHCP acquisition/renewal sequencer: DISCOVER retries, lease tracking, renewal at T1.
// Define DHCP_RETRY_BACKOFF_EN for exponential DISCOVER retry backoff (capped at 8x RETRY_SEC).
module dhcp_lease_timer #(
    parameter int unsigned CLK_HZ      = 125000000,
    parameter int unsigned RETRY_SEC   = 4,
    parameter int unsigned MAX_RETRIES = 4
) (
    input  logic               tx_clock,
    input  logic               reset,
    input  logic               link_up,
    dhcp_lease_timer_if.master dhcp,
    output logic               ip_valid,
    output logic               dhcp_give_up,
    output logic               lease_expired
);

    typedef enum logic [2:0] {
        WAIT_LINK,
        DISCOVER,
        WAIT_REPLY,
        BIND,
        BOUND,
        RENEW,
        WAIT_RENEW,
        GIVE_UP
    } state_e;

    localparam logic [31:0] PRESC_MAX = 32'(CLK_HZ - 1);
    localparam logic [31:0] RETRY_LD  = 32'(RETRY_SEC);
    localparam logic [31:0] RETRY_CAP = 32'(RETRY_SEC * 8);
    localparam logic [31:0] RETRY_LIM = 32'(MAX_RETRIES);
    localparam logic [31:0] LEASE_INF = 32'hFFFF_FFFF;

    function automatic logic [31:0] dec_sat(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

    logic [31:0] presc_q;
    logic        tick;
    logic        succ_hist_q, fail_hist_q;
    logic        succ_edge_q, fail_edge_q;
    logic [31:0] lease_q;
    logic [31:0] disc_ivl;

    state_e      state_q, state_d;
    logic [31:0] retry_cnt_q, retry_cnt_d;
    logic [31:0] retry_tmr_q, retry_tmr_d;
    logic [31:0] t1_q, t1_d;
    logic [31:0] expiry_q, expiry_d;
    logic        inf_q, inf_d;
    logic [3:0]  secs_q, secs_d;
    logic        ip_valid_q, ip_valid_d;
    logic        give_up_q, give_up_d;
    logic        req_q, req_d;
    logic        expired_q, expired_d;

    assign tick = (presc_q == PRESC_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tx_clock) begin
        if (reset) begin
            presc_q <= 32'd0;
        end else begin
            presc_q <= tick ? 32'd0 : presc_q + 32'd1;
        end
    end

    // NOTE: the history copies load even while reset is held, so an input that is already high
    // at reset release is not taken for a rising edge; only the edge flags are cleared.
    always_ff @(posedge tx_clock) begin
        succ_hist_q <= dhcp.dhcp_success;
        fail_hist_q <= dhcp.dhcp_failed;
    end

    always_ff @(posedge tx_clock) begin
        if (reset) begin
            succ_edge_q <= 1'b0;
            fail_edge_q <= 1'b0;
            lease_q     <= 32'd0;
        end else begin
            succ_edge_q <= dhcp.dhcp_success & ~succ_hist_q;
            fail_edge_q <= dhcp.dhcp_failed & ~fail_hist_q;
            if (dhcp.dhcp_success && !succ_hist_q) begin
                lease_q <= dhcp.lease;
            end
        end
    end

`ifdef DHCP_RETRY_BACKOFF_EN
    // retry_cnt_q still holds the pre-increment count here, i.e. (retry_cnt - 1).
    always_comb begin
        if (retry_cnt_q >= 32'd3) begin
            disc_ivl = RETRY_CAP;
        end else begin
            disc_ivl = RETRY_LD << retry_cnt_q[1:0];
        end
    end
`else
    always_comb begin
        disc_ivl = RETRY_LD;
    end
`endif

    // NOTE: every variable written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        retry_tmr_d = retry_tmr_q;
        t1_d        = t1_q;
        expiry_d    = expiry_q;
        inf_d       = inf_q;
        secs_d      = secs_q;
        ip_valid_d  = ip_valid_q;
        give_up_d   = give_up_q;
        req_d       = 1'b0;
        expired_d   = 1'b0;

        if (tick && secs_q != 4'hF &&
            (state_q inside {DISCOVER, WAIT_REPLY, RENEW, WAIT_RENEW})) begin
            secs_d = secs_q + 4'd1;
        end

        unique case (state_q)
            WAIT_LINK: begin
                if (link_up) begin
                    retry_cnt_d = 32'd0;
                    secs_d      = 4'd0;
                    state_d     = DISCOVER;
                end
            end
            DISCOVER: begin
                req_d       = 1'b1;
                retry_tmr_d = disc_ivl;
                retry_cnt_d = retry_cnt_q + 32'd1;
                state_d     = WAIT_REPLY;
            end
            WAIT_REPLY: begin
                if (tick) retry_tmr_d = dec_sat(retry_tmr_q);
                if (succ_edge_q) begin
                    ip_valid_d = 1'b1;
                    state_d    = BIND;
                end else if (fail_edge_q || retry_tmr_q == 32'd0) begin
                    if (retry_cnt_q < RETRY_LIM) begin
                        state_d = DISCOVER;
                    end else begin
                        give_up_d = 1'b1;
                        state_d   = GIVE_UP;
                    end
                end
            end
            BIND: begin
                t1_d     = ((lease_q >> 1) == 32'd0) ? 32'd1 : (lease_q >> 1);
                expiry_d = lease_q;
                inf_d    = (lease_q == LEASE_INF);
                secs_d   = 4'd0;
                state_d  = BOUND;
            end
            BOUND: begin
                if (!inf_q) begin
                    if (tick) begin
                        t1_d     = dec_sat(t1_q);
                        expiry_d = dec_sat(expiry_q);
                    end
                    if (t1_q == 32'd0) begin
                        secs_d  = 4'd0;
                        state_d = RENEW;
                    end
                end
            end
            RENEW: begin
                req_d       = 1'b1;
                retry_tmr_d = RETRY_LD;
                if (tick) expiry_d = dec_sat(expiry_q);
                state_d     = WAIT_RENEW;
            end
            WAIT_RENEW: begin
                if (tick) begin
                    expiry_d    = dec_sat(expiry_q);
                    retry_tmr_d = dec_sat(retry_tmr_q);
                end
                // Expiry is tested before the retry timer so a coincident timeout restarts discovery.
                if (succ_edge_q) begin
                    ip_valid_d = 1'b1;
                    state_d    = BIND;
                end else if (fail_edge_q) begin
                    ip_valid_d  = 1'b0;
                    retry_cnt_d = 32'd0;
                    state_d     = DISCOVER;
                end else if (expiry_q == 32'd0) begin
                    expired_d   = 1'b1;
                    ip_valid_d  = 1'b0;
                    retry_cnt_d = 32'd0;
                    state_d     = DISCOVER;
                end else if (retry_tmr_q == 32'd0) begin
                    state_d = RENEW;
                end
            end
            GIVE_UP: begin
                give_up_d = 1'b1;
            end
            default: state_d = WAIT_LINK;
        endcase

        if (!link_up) begin
            state_d     = WAIT_LINK;
            retry_cnt_d = 32'd0;
            retry_tmr_d = 32'd0;
            t1_d        = 32'd0;
            expiry_d    = 32'd0;
            inf_d       = 1'b0;
            secs_d      = 4'd0;
            ip_valid_d  = 1'b0;
            give_up_d   = 1'b0;
            req_d       = 1'b0;
            expired_d   = 1'b0;
        end
    end

    always_ff @(posedge tx_clock) begin
        if (reset) begin
            state_q     <= WAIT_LINK;
            retry_cnt_q <= 32'd0;
            retry_tmr_q <= 32'd0;
            t1_q        <= 32'd0;
            expiry_q    <= 32'd0;
            inf_q       <= 1'b0;
            secs_q      <= 4'd0;
            ip_valid_q  <= 1'b0;
            give_up_q   <= 1'b0;
            req_q       <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            retry_tmr_q <= retry_tmr_d;
            t1_q        <= t1_d;
            expiry_q    <= expiry_d;
            inf_q       <= inf_d;
            secs_q      <= secs_d;
            ip_valid_q  <= ip_valid_d;
            give_up_q   <= give_up_d;
            req_q       <= req_d;
            expired_q   <= expired_d;
        end
    end

    assign dhcp.dhcp_request       = req_q;
    assign dhcp.dhcp_seconds_timer = secs_q;
    assign ip_valid                = ip_valid_q;
    assign dhcp_give_up            = give_up_q;
    assign lease_expired           = expired_q;

endmodule

// File: tb/tb_dhcp_lease_timer.sv
// Directed bench for dhcp_lease_timer with CLK_HZ=10, RETRY_SEC=2, MAX_RETRIES=3.
module tb_dhcp_lease_timer;

    localparam int CLK_HZ      = 10;
    localparam int RETRY_SEC   = 2;
    localparam int MAX_RETRIES = 3;

`ifdef DHCP_RETRY_BACKOFF_EN
    localparam int GU_REQ3 = 62;
    localparam int GU_CYC  = 141;
    localparam int GU_SECS = 14;
`else
    localparam int GU_REQ3 = 42;
    localparam int GU_CYC  = 61;
    localparam int GU_SECS = 6;
`endif

    logic tx_clock = 1'b0;
    logic reset    = 1'b1;
    logic link_up  = 1'b0;
    logic ip_valid;
    logic dhcp_give_up;
    logic lease_expired;

    dhcp_lease_timer_if dhcp_bus ();

    dhcp_lease_timer #(
        .CLK_HZ      (CLK_HZ),
        .RETRY_SEC   (RETRY_SEC),
        .MAX_RETRIES (MAX_RETRIES)
    ) dut (
        .tx_clock      (tx_clock),
        .reset         (reset),
        .link_up       (link_up),
        .dhcp          (dhcp_bus.master),
        .ip_valid      (ip_valid),
        .dhcp_give_up  (dhcp_give_up),
        .lease_expired (lease_expired)
    );

    always #5 tx_clock = ~tx_clock;

    // Cycle index: 0 at the last reset edge, ticks land on multiples of 10.
    int cyc = 0;
    always @(posedge tx_clock) cyc = reset ? 0 : cyc + 1;

    int req_log[$];
    int exp_req[$];
    always @(negedge tx_clock) begin
        if (dhcp_bus.dhcp_request === 1'b1) req_log.push_back(cyc);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reqs(input string tag);
        check({tag, "_count"}, 32'(req_log.size()), 32'(exp_req.size()));
        foreach (exp_req[i]) begin
            check($sformatf("%s_req%0d", tag, i),
                  (i < req_log.size()) ? 32'(req_log[i]) : 32'hFFFF_FFFF, 32'(exp_req[i]));
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge tx_clock);
    endtask

    task automatic reset_dut(input logic succ_lvl);
        @(negedge tx_clock);
        reset                 = 1'b1;
        link_up               = 1'b0;
        dhcp_bus.dhcp_success = succ_lvl;
        dhcp_bus.dhcp_failed  = 1'b0;
        dhcp_bus.lease        = 32'd0;
        repeat (3) @(negedge tx_clock);
        reset = 1'b0;
        req_log.delete();
    endtask

    // Link up at cycle 0, success with the given lease at cycle 4, success dropped at cycle 8.
    task automatic bind_with(input logic [31:0] lease_val);
        link_up = 1'b1;
        wait_cyc(4);
        dhcp_bus.dhcp_success = 1'b1;
        dhcp_bus.lease        = lease_val;
        wait_cyc(8);
        dhcp_bus.dhcp_success = 1'b0;
    endtask

    initial begin
        // Discovery give-up, with dhcp_success already high through reset.
        reset_dut(1'b1);
        check("rst_ip_valid", 32'(ip_valid), 0);
        check("rst_give_up", 32'(dhcp_give_up), 0);
        check("rst_expired", 32'(lease_expired), 0);
        check("rst_request", 32'(dhcp_bus.dhcp_request), 0);
        check("rst_secs", 32'(dhcp_bus.dhcp_seconds_timer), 0);
        link_up = 1'b1;
        wait_cyc(1);
        check("req_lat1", 32'(dhcp_bus.dhcp_request), 0);
        wait_cyc(2);
        check("req_lat2", 32'(dhcp_bus.dhcp_request), 1);
        wait_cyc(3);
        check("req_width", 32'(dhcp_bus.dhcp_request), 0);
        wait_cyc(10);
        check("secs_tick", 32'(dhcp_bus.dhcp_seconds_timer), 1);
        wait_cyc(GU_CYC - 1);
        check("gu_before", 32'(dhcp_give_up), 0);
        wait_cyc(GU_CYC);
        check("gu_set", 32'(dhcp_give_up), 1);
        check("gu_secs", 32'(dhcp_bus.dhcp_seconds_timer), 32'(GU_SECS));
        check("gu_ip_valid", 32'(ip_valid), 0);
        wait_cyc(GU_CYC + 200);
        exp_req = '{2, 22, GU_REQ3};
        check_reqs("giveup");
        link_up = 1'b0;
        wait_cyc(GU_CYC + 201);
        check("gu_cleared", 32'(dhcp_give_up), 0);

        // Link drop in WAIT_REPLY, then a full discovery run after re-link.
        reset_dut(1'b0);
        link_up = 1'b1;
        wait_cyc(5);
        link_up = 1'b0;
        wait_cyc(100);
        check("drop_quiet", 32'(req_log.size()), 1);
        check("drop_secs", 32'(dhcp_bus.dhcp_seconds_timer), 0);
        link_up = 1'b1;
        wait_cyc(100 + GU_CYC - 1);
        check("relink_gu_before", 32'(dhcp_give_up), 0);
        wait_cyc(100 + GU_CYC);
        check("relink_gu_set", 32'(dhcp_give_up), 1);
        check("relink_secs", 32'(dhcp_bus.dhcp_seconds_timer), 32'(GU_SECS));
        wait_cyc(100 + GU_CYC + 5);
        exp_req = '{2, 102, 122, 100 + GU_REQ3};
        check_reqs("relink");

        // Normal renewal: two successes, renewal 5 s after each bind.
        reset_dut(1'b0);
        bind_with(32'd10);
        wait_cyc(54);
        dhcp_bus.dhcp_success = 1'b1;
        wait_cyc(56);
        check("renew_ip_valid", 32'(ip_valid), 1);
        wait_cyc(58);
        dhcp_bus.dhcp_success = 1'b0;
        wait_cyc(103);
        exp_req = '{2, 52, 102};
        check_reqs("renew");

        // Bind latency: ip_valid rises two cycles after dhcp_success.
        reset_dut(1'b0);
        link_up = 1'b1;
        wait_cyc(4);
        dhcp_bus.dhcp_success = 1'b1;
        dhcp_bus.lease        = 32'd10;
        wait_cyc(5);
        check("bind_lat1", 32'(ip_valid), 0);
        wait_cyc(6);
        check("bind_lat2", 32'(ip_valid), 1);
        wait_cyc(8);
        dhcp_bus.dhcp_success = 1'b0;

        // Lease expiry: renewals unanswered at 5, 7, 9 s; expiry at 10 s.
        reset_dut(1'b0);
        bind_with(32'd10);
        wait_cyc(100);
        check("exp_ip_before", 32'(ip_valid), 1);
        check("exp_pulse_before", 32'(lease_expired), 0);
        wait_cyc(101);
        check("exp_pulse", 32'(lease_expired), 1);
        check("exp_ip_cleared", 32'(ip_valid), 0);
        check("exp_secs", 32'(dhcp_bus.dhcp_seconds_timer), 5);
        wait_cyc(102);
        check("exp_pulse_width", 32'(lease_expired), 0);
        check("exp_discover", 32'(dhcp_bus.dhcp_request), 1);
        wait_cyc(110);
        exp_req = '{2, 52, 72, 92, 102};
        check_reqs("expiry");

        // NAK during renewal.
        reset_dut(1'b0);
        bind_with(32'd10);
        wait_cyc(54);
        dhcp_bus.dhcp_failed = 1'b1;
        wait_cyc(55);
        check("nak_ip_before", 32'(ip_valid), 1);
        wait_cyc(56);
        check("nak_ip_cleared", 32'(ip_valid), 0);
        check("nak_no_expired", 32'(lease_expired), 0);
        wait_cyc(60);
        exp_req = '{2, 52, 57};
        check_reqs("nak");

        // Infinite lease: no renewal for 1000 s.
        reset_dut(1'b0);
        bind_with(32'hFFFF_FFFF);
        wait_cyc(10100);
        check("inf_ip_valid", 32'(ip_valid), 1);
        check("inf_secs", 32'(dhcp_bus.dhcp_seconds_timer), 0);
        exp_req = '{2};
        check_reqs("inf");

        // Lease 64: seconds timer saturates; expiry and retry timeout coincide at cycle 640.
        reset_dut(1'b0);
        bind_with(32'd64);
        wait_cyc(495);
        check("sat_secs", 32'(dhcp_bus.dhcp_seconds_timer), 15);
        wait_cyc(640);
        check("coinc_ip_before", 32'(ip_valid), 1);
        wait_cyc(641);
        check("coinc_expired", 32'(lease_expired), 1);
        check("coinc_ip_cleared", 32'(ip_valid), 0);
        check("coinc_secs", 32'(dhcp_bus.dhcp_seconds_timer), 15);
        wait_cyc(650);
        exp_req.delete();
        exp_req.push_back(2);
        for (int k = 0; k < 16; k++) exp_req.push_back(322 + 20 * k);
        exp_req.push_back(642);
        check_reqs("long");

        // Lease 1: T1 forced to 1 s, expiry right after the first renewal.
        reset_dut(1'b0);
        bind_with(32'd1);
        wait_cyc(12);
        check("l1_renew", 32'(dhcp_bus.dhcp_request), 1);
        wait_cyc(13);
        check("l1_expired", 32'(lease_expired), 1);
        check("l1_ip_cleared", 32'(ip_valid), 0);
        wait_cyc(20);
        exp_req = '{2, 12, 14};
        check_reqs("lease1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
